// File: rtl/hcms_rx_if.sv
// HCMS display serial bus bundle: the transmitter-driven serial lines plus
// the byte stream and decoded control registers recovered from them.
interface hcms_rx_if;
   logic       i_hcms_data;
   logic       i_hcms_clock;
   logic       i_hcms_regsel;
   logic       i_hcms_ncs;
   logic       i_hcms_nreset;

   logic [7:0] o_byte;
   logic       o_byte_valid;
   logic       o_byte_is_cmd;
   logic [7:0] o_dot_index;
   logic       o_frame_err;
   logic       o_busy;
   logic [3:0] o_brightness;
   logic [1:0] o_peak_current;
   logic       o_sleep_n;
   logic [1:0] o_ctrl1;

   // Transmitter side: drives the serial lines, observes the decoded outputs.
   modport master (
      output i_hcms_data, i_hcms_clock, i_hcms_regsel, i_hcms_ncs, i_hcms_nreset,
      input  o_byte, o_byte_valid, o_byte_is_cmd, o_dot_index, o_frame_err,
      input  o_busy, o_brightness, o_peak_current, o_sleep_n, o_ctrl1
   );

   // Receiver side: samples the serial lines, drives the decoded outputs.
   modport slave (
      input  i_hcms_data, i_hcms_clock, i_hcms_regsel, i_hcms_ncs, i_hcms_nreset,
      output o_byte, o_byte_valid, o_byte_is_cmd, o_dot_index, o_frame_err,
      output o_busy, o_brightness, o_peak_current, o_sleep_n, o_ctrl1
   );
endinterface

// File: rtl/hcms_rx.sv
// HCMS-style display serial receiver. Oversamples the serial bus on i_CLK,
// reassembles bytes MSB first, tags dot bytes with their position in the
// dot register and decodes control words into the control registers.
// Pipeline: 2 sync flops -> edge detect/FSM -> event register -> outputs,
// giving 4 i_CLK cycles from a pin edge to o_byte_valid.
module hcms_rx #(
   parameter int DOT_BYTES = 20
) (
   input logic    i_CLK,
   input logic    i_nReset,
   hcms_rx_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] LAST_INDEX = 8'(DOT_BYTES - 1);

   // synchronizer chains, bit 1 is the synchronized value
   logic [1:0] data_sync_r;
   logic [1:0] sclk_sync_r;
   logic [1:0] regsel_sync_r;
   logic [1:0] ncs_sync_r;
   logic [1:0] nrst_sync_r;
   logic       sclk_dly_r;
   logic       ncs_dly_r;

   logic       data_s;
   logic       sclk_s;
   logic       regsel_s;
   logic       ncs_s;
   logic       soft_rst_s;
   logic       sclk_rise_s;
   logic       ncs_fall_s;
   logic       ncs_rise_s;

   // frame state
   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] shift_r;
   logic [7:0] shift_nxt_s;
   logic [2:0] bit_cnt_r;
   logic [2:0] bit_cnt_nxt_s;
   logic       cmd_frame_r;
   logic       cmd_frame_nxt_s;
   logic [7:0] dot_index_r;
   logic [7:0] dot_index_nxt_s;

   logic [7:0] shifted_s;
   logic       byte_done_s;

   // completed-byte / error events, one cycle ahead of the outputs
   logic       ev_valid_s;
   logic [7:0] ev_byte_s;
   logic       ev_cmd_s;
   logic [7:0] ev_index_s;
   logic       ev_err_s;
   logic       ev_valid_r;
   logic [7:0] ev_byte_r;
   logic       ev_cmd_r;
   logic [7:0] ev_index_r;
   logic       ev_err_r;

   // Two-flop synchronizers for every serial line plus one-cycle delayed copies for edge detection.
   always_ff @(posedge i_CLK or negedge i_nReset) begin
      if (!i_nReset) begin
         data_sync_r   <= 2'b00;
         sclk_sync_r   <= 2'b00;
         regsel_sync_r <= 2'b00;
         ncs_sync_r    <= 2'b11;
         nrst_sync_r   <= 2'b11;
         sclk_dly_r    <= 1'b0;
         ncs_dly_r     <= 1'b1;
      end else begin
         data_sync_r   <= {data_sync_r[0],   bus.i_hcms_data};
         sclk_sync_r   <= {sclk_sync_r[0],   bus.i_hcms_clock};
         regsel_sync_r <= {regsel_sync_r[0], bus.i_hcms_regsel};
         ncs_sync_r    <= {ncs_sync_r[0],    bus.i_hcms_ncs};
         nrst_sync_r   <= {nrst_sync_r[0],   bus.i_hcms_nreset};
         sclk_dly_r    <= sclk_sync_r[1];
         ncs_dly_r     <= ncs_sync_r[1];
      end
   end

   assign data_s      = data_sync_r[1];
   assign sclk_s      = sclk_sync_r[1];
   assign regsel_s    = regsel_sync_r[1];
   assign ncs_s       = ncs_sync_r[1];
   assign soft_rst_s  = ~nrst_sync_r[1];
   assign sclk_rise_s = sclk_s & ~sclk_dly_r;
   assign ncs_fall_s  = ~ncs_s & ncs_dly_r;
   assign ncs_rise_s  = ncs_s & ~ncs_dly_r;

   assign shifted_s   = {shift_r[6:0], data_s};
   assign byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7);

   // Next-state and event decode; a same-cycle sclk edge is folded in before the frame close.
   always_comb begin
      state_nxt_s     = state_r;
      shift_nxt_s     = shift_r;
      bit_cnt_nxt_s   = bit_cnt_r;
      cmd_frame_nxt_s = cmd_frame_r;
      dot_index_nxt_s = dot_index_r;
      ev_valid_s      = 1'b0;
      ev_byte_s       = 8'h00;
      ev_cmd_s        = 1'b0;
      ev_index_s      = dot_index_r;
      ev_err_s        = 1'b0;

      case (state_r)
         IDLE: begin
            if (ncs_fall_s) begin
               state_nxt_s     = SHIFT;
               cmd_frame_nxt_s = regsel_s;
               bit_cnt_nxt_s   = 3'd0;
               shift_nxt_s     = 8'h00;
            end else begin
               state_nxt_s     = IDLE;
            end
         end

         SHIFT: begin
            if (sclk_rise_s) begin
               shift_nxt_s   = shifted_s;
               bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            end else begin
               shift_nxt_s   = shift_r;
               bit_cnt_nxt_s = bit_cnt_r;
            end

            // dot bytes are emitted as they complete; the frame keeps shifting
            if (byte_done_s && !cmd_frame_r) begin
               ev_valid_s = 1'b1;
               ev_byte_s  = shifted_s;
               ev_cmd_s   = 1'b0;
               ev_index_s = dot_index_r;
               if (dot_index_r == LAST_INDEX) begin
                  dot_index_nxt_s = 8'd0;
               end else begin
                  dot_index_nxt_s = dot_index_r + 8'd1;
               end
            end else begin
               dot_index_nxt_s = dot_index_r;
            end

            if (ncs_rise_s) begin
               state_nxt_s = IDLE;
               if (cmd_frame_r) begin
                  if (byte_done_s) begin
                     ev_valid_s = 1'b1;
                     ev_byte_s  = shifted_s;
                     ev_cmd_s   = 1'b1;
                  end else begin
                     ev_err_s   = 1'b1;
                  end
               end else if (bit_cnt_nxt_s != 3'd0) begin
                  ev_err_s = 1'b1;
               end else begin
                  ev_err_s = 1'b0;
               end
            end else if (byte_done_s && cmd_frame_r) begin
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = SHIFT;
            end
         end

         HOLD: begin
            // control word is complete; extra clocks are ignored until ncs rises
            if (ncs_rise_s) begin
               state_nxt_s = IDLE;
               ev_valid_s  = 1'b1;
               ev_byte_s   = shift_r;
               ev_cmd_s    = 1'b1;
            end else begin
               state_nxt_s = HOLD;
            end
         end

         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Frame state and event registers; the display reset line aborts silently.
   always_ff @(posedge i_CLK or negedge i_nReset) begin
      if (!i_nReset) begin
         state_r     <= IDLE;
         shift_r     <= 8'h00;
         bit_cnt_r   <= 3'd0;
         cmd_frame_r <= 1'b0;
         dot_index_r <= 8'd0;
         ev_valid_r  <= 1'b0;
         ev_byte_r   <= 8'h00;
         ev_cmd_r    <= 1'b0;
         ev_index_r  <= 8'd0;
         ev_err_r    <= 1'b0;
      end else if (soft_rst_s) begin
         state_r     <= IDLE;
         shift_r     <= 8'h00;
         bit_cnt_r   <= 3'd0;
         cmd_frame_r <= 1'b0;
         dot_index_r <= 8'd0;
         ev_valid_r  <= 1'b0;
         ev_byte_r   <= 8'h00;
         ev_cmd_r    <= 1'b0;
         ev_index_r  <= 8'd0;
         ev_err_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         shift_r     <= shift_nxt_s;
         bit_cnt_r   <= bit_cnt_nxt_s;
         cmd_frame_r <= cmd_frame_nxt_s;
         dot_index_r <= dot_index_nxt_s;
         ev_valid_r  <= ev_valid_s;
         ev_byte_r   <= ev_byte_s;
         ev_cmd_r    <= ev_cmd_s;
         ev_index_r  <= ev_index_s;
         ev_err_r    <= ev_err_s;
      end
   end

   // Output register stage: byte stream, error pulse, busy flag and control register decode.
   always_ff @(posedge i_CLK or negedge i_nReset) begin
      if (!i_nReset) begin
         bus.o_byte         <= 8'h00;
         bus.o_byte_valid   <= 1'b0;
         bus.o_byte_is_cmd  <= 1'b0;
         bus.o_dot_index    <= 8'd0;
         bus.o_frame_err    <= 1'b0;
         bus.o_busy         <= 1'b0;
         bus.o_brightness   <= 4'h0;
         bus.o_peak_current <= 2'd0;
         bus.o_sleep_n      <= 1'b0;
         bus.o_ctrl1        <= 2'd0;
      end else if (soft_rst_s) begin
         bus.o_byte         <= 8'h00;
         bus.o_byte_valid   <= 1'b0;
         bus.o_byte_is_cmd  <= 1'b0;
         bus.o_dot_index    <= 8'd0;
         bus.o_frame_err    <= 1'b0;
         bus.o_busy         <= 1'b0;
         bus.o_brightness   <= 4'h0;
         bus.o_peak_current <= 2'd0;
         bus.o_sleep_n      <= 1'b0;
         bus.o_ctrl1        <= 2'd0;
      end else begin
         bus.o_byte_valid <= ev_valid_r;
         bus.o_frame_err  <= ev_err_r;
         bus.o_busy       <= ~ncs_s;
         if (ev_valid_r) begin
            bus.o_byte        <= ev_byte_r;
            bus.o_byte_is_cmd <= ev_cmd_r;
            if (!ev_cmd_r) begin
               bus.o_dot_index <= ev_index_r;
            end
         end
         if (ev_valid_r && ev_cmd_r) begin
            if (!ev_byte_r[7]) begin
               bus.o_sleep_n      <= ev_byte_r[6];
               bus.o_peak_current <= ev_byte_r[5:4];
               bus.o_brightness   <= ev_byte_r[3:0];
            end else begin
               bus.o_ctrl1        <= ev_byte_r[1:0];
            end
         end
      end
   end

endmodule
